// File: rtl/alu_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_disp_pkg
//  Description : Shared constants for the ALU result display scanner: digit
//                count and the 16-entry hex-to-segment (abcdefg) encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_disp_pkg;

    localparam int c_num_digits = 4;
    localparam int c_digit_w    = 2;
    localparam int c_seg_w      = 7;

    // Index 15 is leftmost; bit 6 of each entry is segment a.
    localparam logic [15:0][6:0] c_seg_lut = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational hex nibble to active-high 7-segment decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import alu_disp_pkg::*;
(
    input  logic [3:0]         hex,
    output logic [c_seg_w-1:0] seg
);

    assign seg = c_seg_lut[hex];

endmodule
`default_nettype wire

// File: rtl/alu_result_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_display_scan
//  Description : Four-digit multiplexed 7-segment display of a history of ALU
//                result nibbles. A one-entry pending register is committed
//                into the history only at frame boundaries.
//                Optional macro BLANK_UNWRITTEN_EN blanks never-written digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_result_display_scan
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         result,
    input  logic               result_valid,
    output logic               result_ready,
    input  logic               en,
    output logic [c_seg_w-1:0] seg,
    output logic [3:0]         an
);

    localparam int c_cnt_w = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_digit_w-1:0] c_last_digit = c_digit_w'(c_num_digits - 1);

    logic [c_cnt_w-1:0]               r_refresh_cnt;
    logic [c_digit_w-1:0]             r_digit_idx;
    logic [c_num_digits-1:0][3:0]     r_hist;
    logic [3:0]                       r_pending;
    logic                             r_pending_full;

    logic                             w_tick;
    logic                             w_frame;
    logic                             w_accept;
    logic                             w_commit;
    logic [3:0]                       w_sel_nibble;
    logic [c_seg_w-1:0]               w_seg_dec;
    logic [c_seg_w-1:0]               w_seg_next;
    logic [3:0]                       w_an_next;

    assign result_ready = ~r_pending_full;
    assign w_tick       = (r_refresh_cnt == c_cnt_max);
    assign w_frame      = w_tick && (r_digit_idx == c_last_digit);
    assign w_accept     = result_valid && ~r_pending_full;
    // Accept needs pending empty, commit needs it full: never both in one cycle.
    assign w_commit     = w_frame && r_pending_full;
    assign w_sel_nibble = r_hist[r_digit_idx];

    seg7_hex_decode u_dec (
        .hex (w_sel_nibble),
        .seg (w_seg_dec)
    );

`ifdef BLANK_UNWRITTEN_EN
    logic [c_num_digits-1:0] r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_commit) begin
            r_valid <= {r_valid[c_num_digits-2:0], 1'b1};
        end
    end

    assign w_seg_next = r_valid[r_digit_idx] ? w_seg_dec : '0;
`else
    assign w_seg_next = w_seg_dec;
`endif

    always_comb begin
        w_an_next              = '0;
        w_an_next[r_digit_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt  <= '0;
            r_digit_idx    <= '0;
            r_hist         <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            seg            <= '0;
            an             <= '0;
        end else begin
            r_refresh_cnt <= w_tick ? '0 : r_refresh_cnt + 1'b1;
            if (w_tick) begin
                r_digit_idx <= r_digit_idx + 1'b1;
            end

            if (w_commit) begin
                r_hist         <= {r_hist[c_num_digits-2:0], r_pending};
                r_pending_full <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= result;
                r_pending_full <= 1'b1;
            end

            // Outputs reflect the scan position and history before this edge.
            seg <= en ? w_seg_next : '0;
            an  <= en ? w_an_next  : '0;
        end
    end

endmodule
`default_nettype wire
